// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad event path: FSM states, key-index
// width, and the one-hot-low scan nibble decoder.
package keypad_pkg;

  localparam int KEY_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    RELEASE_DB
  } key_state_t;

  typedef struct packed {
    logic       valid;
    logic [1:0] idx;
  } nib_dec_t;

  // What the debouncer currently sees: a decoded key, or "no key" (all zero).
  typedef struct packed {
    logic                 ok;
    logic [KEY_IDX_W-1:0] idx;
  } key_obs_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Exactly one low bit is a valid line; its position is the index.
  function automatic nib_dec_t decode_nibble(input logic [3:0] nib);
    nib_dec_t d;
    d = '0;
    case (nib)
      4'b1110: d = '{valid: 1'b1, idx: 2'd0};
      4'b1101: d = '{valid: 1'b1, idx: 2'd1};
      4'b1011: d = '{valid: 1'b1, idx: 2'd2};
      4'b0111: d = '{valid: 1'b1, idx: 2'd3};
      default: d = '0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/keypad_sync_fifo.sv
// Generic circular FIFO with wrap-bit pointers and a registered head entry;
// a push into a full FIFO without a same-cycle pop is dropped and reported.
module keypad_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop_ready,
  output logic [WIDTH-1:0]         head_data,
  output logic                     head_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    rd_ptr_nxt;
  logic [PW-1:0]    remaining;
  logic             full;
  logic             pop;
  logic             do_push;

  assign count      = wr_ptr - rd_ptr;
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = head_valid && pop_ready;
  assign do_push    = push && (!full || pop);
  assign drop       = push && full && !pop;
  assign rd_ptr_nxt = rd_ptr + PW'(pop);
  // Entries already in memory that survive this edge; a push landing on this
  // same edge becomes visible at the head one cycle later.
  assign remaining  = count - PW'(pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      head_valid <= 1'b0;
      head_data  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr     <= rd_ptr_nxt;
      head_valid <= (remaining != '0);
      if (remaining != '0) head_data <= mem[rd_ptr_nxt[AW-1:0]];
    end
  end

  // NOTE: storage has no reset; the pointers alone define which entries are
  // live, so resetting the array would only cost area and reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/keypad_event_fifo.sv
// Keypad event path: synchronizes scanner codes, debounces presses into key
// events and queues them. Define KEYPAD_REPEAT_EN to enable auto-repeat.
module keypad_event_fifo
  import keypad_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int STABLE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [7:0]                  i_scan_code,
  input  logic                        i_scan_valid,
  output logic [KEY_IDX_W-1:0]        o_key_code,
  output logic                        o_key_valid,
  input  logic                        i_key_ready,
  output logic                        o_key_down,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_overflow,
  input  logic                        i_ovf_clr
);

  localparam int CNT_MAX_VAL = max_int(STABLE_CYCLES, max_int(REPEAT_DELAY, REPEAT_PERIOD));
  localparam int CNT_W       = (CNT_MAX_VAL > 2) ? $clog2(CNT_MAX_VAL) : 1;
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [7:0]           code_meta, code_sync;
  logic                 valid_meta, valid_sync;
  nib_dec_t             col_dec, row_dec;
  key_obs_t             obs;
  logic                 match;

  key_state_t           state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt, cnt_inc;
  logic [KEY_IDX_W-1:0] cand, cand_nxt;
  key_obs_t             rel_obs, rel_obs_nxt;
  logic                 db_push;
  logic                 push_evt;
  logic                 fifo_drop;

  // Scan code and flag come from the slow scan clock.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      code_meta  <= '0;
      code_sync  <= '0;
      valid_meta <= 1'b0;
      valid_sync <= 1'b0;
    end else begin
      code_meta  <= i_scan_code;
      code_sync  <= code_meta;
      valid_meta <= i_scan_valid;
      valid_sync <= valid_meta;
    end
  end

  assign col_dec = decode_nibble(code_sync[7:4]);
  assign row_dec = decode_nibble(code_sync[3:0]);
  assign obs.ok  = valid_sync && col_dec.valid && row_dec.valid;
  assign obs.idx = obs.ok ? {row_dec.idx, col_dec.idx} : '0;
  assign match   = obs.ok && (obs.idx == cand);
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cand    <= '0;
      rel_obs <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      cand    <= cand_nxt;
      rel_obs <= rel_obs_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt_inc;
    cand_nxt    = cand;
    rel_obs_nxt = rel_obs;
    db_push     = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (obs.ok) begin
          state_nxt = PRESS_DB;
          cand_nxt  = obs.idx;
        end
      end
      PRESS_DB: begin
        if (!match) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
          db_push   = 1'b1;
        end
      end
      HELD: begin
        cnt_nxt = '0;
        if (!match) begin
          state_nxt   = RELEASE_DB;
          rel_obs_nxt = obs;
        end
      end
      RELEASE_DB: begin
        // Release only counts once whatever replaced the key has itself held
        // steady; any change in the observation restarts the count.
        if (match) begin
          state_nxt = HELD;
          cnt_nxt   = '0;
        end else if (obs != rel_obs) begin
          rel_obs_nxt = obs;
          cnt_nxt     = '0;
        end else if (cnt == STABLE_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [CNT_W-1:0] rpt_cnt, rpt_cnt_nxt;
  logic             rpt_armed, rpt_armed_nxt;
  logic             rpt_push;

  // rpt_armed selects the period once the initial delay has fired.
  always_comb begin
    rpt_cnt_nxt   = '0;
    rpt_armed_nxt = 1'b0;
    rpt_push      = 1'b0;
    if (state == HELD && match) begin
      if (rpt_cnt == (rpt_armed ? PERIOD_LAST : DELAY_LAST)) begin
        rpt_push      = 1'b1;
        rpt_armed_nxt = 1'b1;
      end else begin
        rpt_cnt_nxt   = (rpt_cnt == '1) ? rpt_cnt : rpt_cnt + 1'b1;
        rpt_armed_nxt = rpt_armed;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rpt_cnt   <= '0;
      rpt_armed <= 1'b0;
    end else begin
      rpt_cnt   <= rpt_cnt_nxt;
      rpt_armed <= rpt_armed_nxt;
    end
  end

  assign push_evt = db_push || rpt_push;
`else
  assign push_evt = db_push;
`endif

  assign o_key_down = (state == HELD) || (state == RELEASE_DB);

  keypad_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_IDX_W)
  ) u_fifo (
    .clk        (i_clk),
    .rst        (i_rst),
    .push       (push_evt),
    .push_data  (cand),
    .pop_ready  (i_key_ready),
    .head_data  (o_key_code),
    .head_valid (o_key_valid),
    .count      (o_fifo_count),
    .drop       (fifo_drop)
  );

  // A same-cycle drop wins over the clear.
  always_ff @(posedge i_clk) begin
    if (i_rst)          o_overflow <= 1'b0;
    else if (fifo_drop) o_overflow <= 1'b1;
    else if (i_ovf_clr) o_overflow <= 1'b0;
  end

endmodule

// File: tb/tb_keypad_event_fifo.sv
// Scoreboard bench for keypad_event_fifo: stimulus queues expected events,
// a negedge monitor checks each popped event's code and (optionally) cycle.
module tb_keypad_event_fifo;

  localparam int STABLE = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_code = 8'hFF;
  logic       scan_valid = 1'b0;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready = 1'b0;
  logic       key_down;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       ovf_clr = 1'b0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [3:0] code;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  keypad_event_fifo #(
    .FIFO_DEPTH    (4),
    .STABLE_CYCLES (STABLE),
    .REPEAT_DELAY  (40),
    .REPEAT_PERIOD (16)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_scan_code  (scan_code),
    .i_scan_valid (scan_valid),
    .o_key_code   (key_code),
    .o_key_valid  (key_valid),
    .i_key_ready  (key_ready),
    .o_key_down   (key_down),
    .o_fifo_count (fifo_count),
    .o_overflow   (overflow),
    .i_ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && key_valid && key_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got code 0x%0h at cycle %0d, expected no event", key_code, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_code", 32'(key_code), 32'(e.code));
        if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
      end
    end
  end

  // One debounced press; optional strobes land in the cycle of the push edge.
  task automatic press(input logic [7:0] code, input logic [3:0] idx, input int hold,
                       input bit expect_evt, input bit timed,
                       input bit strobe_rdy, input bit strobe_clr);
    int e;
    scan_code  = code;
    scan_valid = 1'b1;
    e = cyc + 1;
    if (expect_evt) sb.push_back('{code: idx, cyc: timed ? e + STABLE + 3 : -1});
    while (cyc < e + STABLE + 1) step();
    if (strobe_rdy) key_ready = 1'b1;
    if (strobe_clr) ovf_clr = 1'b1;
    step();
    if (strobe_rdy) key_ready = 1'b0;
    if (strobe_clr) ovf_clr = 1'b0;
    check("key_down_held", 32'(key_down), 32'd1);
    while (cyc < e + hold - 1) step();
    scan_valid = 1'b0;
    scan_code  = 8'hFF;
    repeat (14) step();
    check("key_down_released", 32'(key_down), 32'd0);
  endtask

  initial begin
    int e;
    repeat (3) step();
    rst = 1'b0;
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_key_down", 32'(key_down), 32'd0);
    check("rst_key_code", 32'(key_code), 32'd0);

    // Clean press of key 0x4
    key_ready = 1'b1;
    press(8'hED, 4'h4, 20, 1'b1, 1'b1, 1'b0, 1'b0);
    check("clean_sb_empty", sb.size(), 0);

    // Bounce, then hold key 0x7
    for (int i = 0; i < 4; i++) begin
      scan_code  = 8'h7D;
      scan_valid = (i % 2 == 0);
      repeat (3) step();
    end
    press(8'h7D, 4'h7, 20, 1'b1, 1'b1, 1'b0, 1'b0);
    check("bounce_sb_empty", sb.size(), 0);

    // Two low bits in a nibble is not a key
    scan_code  = 8'hCE;
    scan_valid = 1'b1;
    repeat (20) step();
    check("invalid_no_key_down", 32'(key_down), 32'd0);
    scan_valid = 1'b0;
    scan_code  = 8'hFF;
    repeat (4) step();

    // Overflow
    key_ready = 1'b0;
    press(8'hDE, 4'h1, 16, 1'b1, 1'b0, 1'b0, 1'b0);
    press(8'hBD, 4'h6, 16, 1'b1, 1'b0, 1'b0, 1'b0);
    press(8'hDB, 4'h9, 16, 1'b1, 1'b0, 1'b0, 1'b0);
    press(8'hE7, 4'hC, 16, 1'b1, 1'b0, 1'b0, 1'b0);
    press(8'h77, 4'hF, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_count_full", 32'(fifo_count), 32'd4);
    check("ovf_flag_set", 32'(overflow), 32'd1);
    check("ovf_head_valid", 32'(key_valid), 32'd1);
    check("ovf_head_code", 32'(key_code), 32'h1);
    press(8'hBB, 4'hA, 16, 1'b1, 1'b0, 1'b1, 1'b0);
    check("pushpop_full_count", 32'(fifo_count), 32'd4);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    press(8'hB7, 4'hE, 16, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_set_beats_clr", 32'(overflow), 32'd1);
    check("ovf_drop_count", 32'(fifo_count), 32'd4);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_cleared_again", 32'(overflow), 32'd0);
    key_ready = 1'b1;
    repeat (8) step();
    check("drain_count", 32'(fifo_count), 32'd0);
    check("drain_sb_empty", sb.size(), 0);

    // Key change while held: 0x0 then 0x5, no release between
    scan_code  = 8'hEE;
    scan_valid = 1'b1;
    e = cyc + 1;
    sb.push_back('{code: 4'h0, cyc: e + STABLE + 3});
    while (cyc < e + 19) step();
    check("change_key_down_0", 32'(key_down), 32'd1);
    scan_code = 8'hDD;
    e = cyc + 1;
    sb.push_back('{code: 4'h5, cyc: e + 2 * STABLE + 4});
    repeat (30) step();
    check("change_key_down_5", 32'(key_down), 32'd1);
    scan_valid = 1'b0;
    scan_code  = 8'hFF;
    repeat (14) step();
    check("change_released", 32'(key_down), 32'd0);
    check("change_sb_empty", sb.size(), 0);

    // Reset mid-PRESS_DB with two queued events
    key_ready = 1'b0;
    press(8'hBE, 4'h2, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    press(8'hEB, 4'h8, 16, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_reset_count", 32'(fifo_count), 32'd2);
    scan_code  = 8'hD7;
    scan_valid = 1'b1;
    repeat (5) step();
    rst        = 1'b1;
    scan_valid = 1'b0;
    scan_code  = 8'hFF;
    step();
    check("midreset_count", 32'(fifo_count), 32'd0);
    check("midreset_valid", 32'(key_valid), 32'd0);
    check("midreset_key_down", 32'(key_down), 32'd0);
    rst       = 1'b0;
    key_ready = 1'b1;
    repeat (30) step();
    check("post_reset_count", 32'(fifo_count), 32'd0);

    // Long hold of key 0x3
    scan_code  = 8'h7E;
    scan_valid = 1'b1;
    e = cyc + 1;
    sb.push_back('{code: 4'h3, cyc: e + 11});
`ifdef KEYPAD_REPEAT_EN
    sb.push_back('{code: 4'h3, cyc: e + 51});
    sb.push_back('{code: 4'h3, cyc: e + 67});
    sb.push_back('{code: 4'h3, cyc: e + 83});
    sb.push_back('{code: 4'h3, cyc: e + 99});
`endif
    while (cyc < e + 99) step();
    scan_valid = 1'b0;
    scan_code  = 8'hFF;
    repeat (20) step();
    check("hold_sb_empty", sb.size(), 0);
    check("hold_released", 32'(key_down), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
